brick_game_painter: RTL
=======================

Name: brick_game_painter

Overview:
- Downstream of the Vga timing generator. Consumes its Hsync/Vsync/Hpos/Vpos and the shared pixel enable.
- Keeps the TroisBriques game state: three bricks, one ball and one paddle, updated once per frame during vertical blanking.
- Emits a registered 3-bit colour per pixel, plus sync outputs delayed to stay aligned with that colour.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- V_VISIBLE, 480, visible lines per frame
- BALL_SPEED, 2, ball step per frame, each axis
- PADDLE_SPEED, 4, paddle step per frame
- PADDLE_Y, 460, paddle top row; paddle is 80x8

Ports:
- clk, input, 1, system clock
- reset, input, 1, asynchronous, active-high
- enable, input, 1, pixel-rate strobe (one clk in two); same signal that drives Vga
- Hsync_in, input, 1, from Vga
- Vsync_in, input, 1, from Vga
- Hpos, input, 11, current pixel column
- Vpos, input, 11, current pixel line
- btn_left, input, 1, asynchronous button
- btn_right, input, 1, asynchronous button
- btn_start, input, 1, asynchronous button
- Hsync, output, 1, Hsync_in delayed one enable cycle
- Vsync, output, 1, Vsync_in delayed one enable cycle
- rgb, output, 3, {R,G,B} for the pixel, aligned with Hsync/Vsync
- game_over, output, 1, high in LOST or WON

Behaviour:
- Decided: single clock clk; reset asynchronous, active-high.
- Register update rule: every register updates only on clk edges where enable=1, except the button synchronisers, which run every clk.
- Reset values:
  - Outputs: rgb=0, Hsync=1, Vsync=1, game_over=0.
  - Game: state=SERVE, ball=(316,300), dx=+BALL_SPEED, dy=-BALL_SPEED, paddle_x=280, bricks alive=3'b111.
- Buttons: two-flop synchronised; then sampled only at frame_tick.
- frame_tick: enable && Hpos==0 && Vpos==V_VISIBLE. It falls in blanking, so the picture never tears.
- Render pipeline, latency 1 enable cycle:
  - Outside the visible area (Hpos>=H_VISIBLE or Vpos>=V_VISIBLE): rgb=000.
  - Otherwise, first match wins:
    - ball 8x8: 111
    - paddle: 001
    - brick i alive, i=0..2: x in [40+200i, 199+200i], y in [40,59]; colours 100, 010, 110
    - background: 000 in SERVE/PLAY, 100 in LOST, 010 in WON
- Geometry: coordinates are top-left; all rectangle tests are half-open on the right and bottom.
- Paddle, in SERVE and PLAY:
  - Left only: x -= PADDLE_SPEED, clamped to 0.
  - Right only: x += PADDLE_SPEED, clamped to 560.
  - Both or neither pressed: no move.
- Ball, in PLAY only. Arithmetic is 12-bit signed: nx=ball_x+dx, ny=ball_y+dy.
  - X axis: if nx<=0, set x=0 and dx=+. If nx>=632, set x=632 and dx=-. Otherwise x=nx.
  - Y axis, priority order:
    1. ny>=472: state becomes LOST; ball frozen.
    2. Any alive brick overlaps (nx,ny,8x8): clear every overlapping brick; negate dy once; y unchanged.
    3. dy>0, ball_y+8<=PADDLE_Y, ny+8>=PADDLE_Y, and horizontal overlap with the paddle: y=PADDLE_Y-8, dy=-.
    4. ny<=0: y=0, dy=+.
    5. Otherwise y=ny.
- FSM transitions (at frame_tick):
  - SERVE: start pressed → PLAY.
  - PLAY: all bricks clear → WON; ball lost → LOST.
  - LOST or WON: start pressed → SERVE, with all game registers restored to reset values.
- Simultaneous events: X and Y axes resolve independently in the same tick. The WON check uses the brick vector after this tick's clears, so WON is entered on the same tick the last brick clears.
- Mid-frame reset: all registers return to reset values immediately. The first rgb output after reset is based on the new state.

Decomposition:
- Shared include game_defs.vh: geometry constants, colour codes, state encoding (SERVE=0, PLAY=1, LOST=2, WON=3).
- Sub-module ball_engine: owns frame_tick physics, bricks, paddle and FSM. It exports positions, alive vector and state.
- The top level does sync delay and pixel colour selection.

Test Plan (the bench drives Hpos/Vpos directly and produces frame_tick by pulsing Vpos=480, Hpos=0):
1. Reset for 100 ns → rgb=000, Hsync=Vsync=1, game_over=0. Then Hpos=100, Vpos=50 → rgb=100 exactly one enable cycle later.
2. Hpos=700, any Vpos → rgb=000. Hpos=320, Vpos=304 in SERVE → 111 (ball).
3. Start, then 121 ticks → brick2 cleared at tick 121 (nx=558, ny=58); dy becomes +; rgb at (500,50) becomes 000.
4. Continue to tick 158 → ball_x=632, dx negative.
5. Hold btn_left 70 ticks → paddle_x=0, stays 0 at tick 71. btn_left and btn_right together → paddle unchanged.
6. Leave paddle at 0 and let the ball fall → LOST, game_over=1, background 100. Press start → SERVE with reset values, alive=111.

Source files
------------

// File: rtl/brick_game_painter_pkg.sv
// Shared geometry, colour codes, state encoding and rectangle helpers for the
// TroisBriques painter and its game engine.
package brick_game_painter_pkg;

  typedef logic signed [11:0] coord_t;

  localparam coord_t H_VISIBLE    = 12'sd640;
  localparam coord_t V_VISIBLE    = 12'sd480;
  localparam coord_t BALL_SPEED   = 12'sd2;
  localparam coord_t PADDLE_SPEED = 12'sd4;
  localparam coord_t PADDLE_Y     = 12'sd460;
  localparam coord_t PADDLE_W     = 12'sd80;
  localparam coord_t PADDLE_H     = 12'sd8;
  localparam coord_t PADDLE_X_MAX = 12'sd560;
  localparam coord_t BALL_SIZE    = 12'sd8;
  localparam coord_t BALL_X_MAX   = 12'sd632;
  localparam coord_t BALL_Y_LOST  = 12'sd472;
  localparam coord_t BRICK_X0     = 12'sd40;
  localparam coord_t BRICK_PITCH  = 12'sd200;
  localparam coord_t BRICK_W      = 12'sd160;
  localparam coord_t BRICK_Y0     = 12'sd40;
  localparam coord_t BRICK_H      = 12'sd20;
  localparam coord_t BALL_X_RST   = 12'sd316;
  localparam coord_t BALL_Y_RST   = 12'sd300;
  localparam coord_t PADDLE_X_RST = 12'sd280;
  localparam int     NUM_BRICKS   = 3;

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_LOST  = 2'd2;
  localparam logic [1:0] ST_WON   = 2'd3;

  localparam logic [2:0] COL_BLACK  = 3'b000;
  localparam logic [2:0] COL_BLUE   = 3'b001;
  localparam logic [2:0] COL_GREEN  = 3'b010;
  localparam logic [2:0] COL_RED    = 3'b100;
  localparam logic [2:0] COL_YELLOW = 3'b110;
  localparam logic [2:0] COL_WHITE  = 3'b111;

  typedef struct packed {
    coord_t     ball_x;
    coord_t     ball_y;
    coord_t     paddle_x;
    logic [2:0] alive;
    logic [1:0] state;
  } game_view_t;

  // Half-open 1-D overlap of [a, a+a_len) and [b, b+b_len); a point test uses a_len=1.
  function automatic logic span_hit(coord_t a, coord_t a_len, coord_t b, coord_t b_len);
    return (a < b + b_len) && (a + a_len > b);
  endfunction

  function automatic coord_t brick_left(logic [1:0] idx);
    coord_t idx_s;
    idx_s = coord_t'({10'b0, idx});
    return BRICK_X0 + BRICK_PITCH * idx_s;
  endfunction

endpackage

// File: rtl/brick_game_painter_if.sv
// Video stream between the Vga timing generator, the painter and the display.
interface brick_game_painter_if;
  logic        enable;
  logic        Hsync_in;
  logic        Vsync_in;
  logic [10:0] Hpos;
  logic [10:0] Vpos;
  logic        Hsync;
  logic        Vsync;
  logic [2:0]  rgb;

  modport master (output enable, Hsync_in, Vsync_in, Hpos, Vpos, input Hsync, Vsync, rgb);
  modport slave  (input enable, Hsync_in, Vsync_in, Hpos, Vpos, output Hsync, Vsync, rgb);
endinterface

// File: rtl/brick_game_painter_ball_engine.sv
// Once-per-frame game update: paddle, ball physics, brick clearing and game FSM.
module brick_game_painter_ball_engine
  import brick_game_painter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [10:0] hpos,
  input  logic [10:0] vpos,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_start,
  output game_view_t  view
);

  logic [2:0] btn_meta_r, btn_sync_r;
  coord_t     ball_x_r, ball_y_r, paddle_x_r;
  logic       dx_pos_r, dy_pos_r;
  logic [2:0] alive_r;
  logic [1:0] state_r;
  coord_t     ball_x_s, ball_y_s, paddle_x_s, paddle_mv_s, nx_s, ny_s;
  logic       dx_pos_s, dy_pos_s, paddle_hit_s, frame_tick_s;
  logic [2:0] alive_s, hit_s;
  logic [1:0] state_s;
  logic       left_s, right_s, start_s;

  assign left_s       = btn_sync_r[0];
  assign right_s      = btn_sync_r[1];
  assign start_s      = btn_sync_r[2];
  assign frame_tick_s = enable && (hpos == 11'd0) && (coord_t'({1'b0, vpos}) == V_VISIBLE);

  // Button synchronisers run every clk, independent of the pixel strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_meta_r <= 3'b000;
      btn_sync_r <= 3'b000;
    end else begin
      btn_meta_r <= {btn_start, btn_right, btn_left};
      btn_sync_r <= btn_meta_r;
    end
  end

  // Paddle candidate position; opposing buttons cancel out.
  always_comb begin
    if (left_s && !right_s) begin
      paddle_mv_s = (paddle_x_r < PADDLE_SPEED) ? 12'sd0 : paddle_x_r - PADDLE_SPEED;
    end else if (right_s && !left_s) begin
      paddle_mv_s = (paddle_x_r + PADDLE_SPEED > PADDLE_X_MAX) ? PADDLE_X_MAX : paddle_x_r + PADDLE_SPEED;
    end else begin
      paddle_mv_s = paddle_x_r;
    end
  end

  // Next game state; collisions are judged against the pre-tick paddle.
  always_comb begin
    nx_s  = ball_x_r + (dx_pos_r ? BALL_SPEED : -BALL_SPEED);
    ny_s  = ball_y_r + (dy_pos_r ? BALL_SPEED : -BALL_SPEED);
    hit_s = 3'b000;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      hit_s[i] = alive_r[i] && span_hit(nx_s, BALL_SIZE, brick_left(2'(i)), BRICK_W)
                 && span_hit(ny_s, BALL_SIZE, BRICK_Y0, BRICK_H);
    end
    paddle_hit_s = dy_pos_r && (ball_y_r + BALL_SIZE <= PADDLE_Y) && (ny_s + BALL_SIZE >= PADDLE_Y)
                   && span_hit(nx_s, BALL_SIZE, paddle_x_r, PADDLE_W);
    ball_x_s   = ball_x_r;
    ball_y_s   = ball_y_r;
    dx_pos_s   = dx_pos_r;
    dy_pos_s   = dy_pos_r;
    paddle_x_s = paddle_x_r;
    alive_s    = alive_r;
    state_s    = state_r;
    case (state_r)
      ST_SERVE: begin
        paddle_x_s = paddle_mv_s;
        if (start_s) state_s = ST_PLAY;
        else         state_s = ST_SERVE;
      end
      ST_PLAY: begin
        paddle_x_s = paddle_mv_s;
        if (ny_s >= BALL_Y_LOST) begin
          state_s = ST_LOST;
        end else begin
          if (nx_s <= 12'sd0) begin
            ball_x_s = 12'sd0;
            dx_pos_s = 1'b1;
          end else if (nx_s >= BALL_X_MAX) begin
            ball_x_s = BALL_X_MAX;
            dx_pos_s = 1'b0;
          end else begin
            ball_x_s = nx_s;
          end
          if (hit_s != 3'b000) begin
            alive_s  = alive_r & ~hit_s;
            dy_pos_s = ~dy_pos_r;
          end else if (paddle_hit_s) begin
            ball_y_s = PADDLE_Y - BALL_SIZE;
            dy_pos_s = 1'b0;
          end else if (ny_s <= 12'sd0) begin
            ball_y_s = 12'sd0;
            dy_pos_s = 1'b1;
          end else begin
            ball_y_s = ny_s;
          end
          if (alive_s == 3'b000) state_s = ST_WON;
          else                   state_s = ST_PLAY;
        end
      end
      ST_LOST, ST_WON: begin
        if (start_s) begin
          ball_x_s   = BALL_X_RST;
          ball_y_s   = BALL_Y_RST;
          dx_pos_s   = 1'b1;
          dy_pos_s   = 1'b0;
          paddle_x_s = PADDLE_X_RST;
          alive_s    = 3'b111;
          state_s    = ST_SERVE;
        end else begin
          state_s = state_r;
        end
      end
      default: state_s = ST_SERVE;
    endcase
  end

  // Game registers commit only on the blanking-interval frame tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ball_x_r   <= BALL_X_RST;
      ball_y_r   <= BALL_Y_RST;
      dx_pos_r   <= 1'b1;
      dy_pos_r   <= 1'b0;
      paddle_x_r <= PADDLE_X_RST;
      alive_r    <= 3'b111;
      state_r    <= ST_SERVE;
    end else if (frame_tick_s) begin
      ball_x_r   <= ball_x_s;
      ball_y_r   <= ball_y_s;
      dx_pos_r   <= dx_pos_s;
      dy_pos_r   <= dy_pos_s;
      paddle_x_r <= paddle_x_s;
      alive_r    <= alive_s;
      state_r    <= state_s;
    end
  end

  assign view = '{ball_x: ball_x_r, ball_y: ball_y_r, paddle_x: paddle_x_r,
                  alive: alive_r, state: state_r};

endmodule

// File: rtl/brick_game_painter.sv
// TroisBriques painter: colours each pixel from the game state and delays the
// syncs by one pixel so they stay aligned with the registered colour.
module brick_game_painter
  import brick_game_painter_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  brick_game_painter_if.slave   vga,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  btn_start,
  output logic                  game_over
);

  game_view_t view_s;
  coord_t     h_s, v_s;
  logic [2:0] brick_px_s, colour_s, rgb_r;
  logic       hsync_r, vsync_r, game_over_r;

  brick_game_painter_ball_engine u_engine (
    .clk       (clk),
    .reset     (reset),
    .enable    (vga.enable),
    .hpos      (vga.Hpos),
    .vpos      (vga.Vpos),
    .btn_left  (btn_left),
    .btn_right (btn_right),
    .btn_start (btn_start),
    .view      (view_s)
  );

  assign h_s = coord_t'({1'b0, vga.Hpos});
  assign v_s = coord_t'({1'b0, vga.Vpos});

  // Per-brick pixel hit for live bricks only.
  always_comb begin
    brick_px_s = 3'b000;
    for (int i = 0; i < NUM_BRICKS; i++) begin
      brick_px_s[i] = view_s.alive[i] && span_hit(h_s, 12'sd1, brick_left(2'(i)), BRICK_W)
                      && span_hit(v_s, 12'sd1, BRICK_Y0, BRICK_H);
    end
  end

  // Pixel colour, first match wins; the background reports the game outcome.
  always_comb begin
    colour_s = COL_BLACK;
    if (h_s >= H_VISIBLE || v_s >= V_VISIBLE) begin
      colour_s = COL_BLACK;
    end else if (span_hit(h_s, 12'sd1, view_s.ball_x, BALL_SIZE)
                 && span_hit(v_s, 12'sd1, view_s.ball_y, BALL_SIZE)) begin
      colour_s = COL_WHITE;
    end else if (span_hit(h_s, 12'sd1, view_s.paddle_x, PADDLE_W)
                 && span_hit(v_s, 12'sd1, PADDLE_Y, PADDLE_H)) begin
      colour_s = COL_BLUE;
    end else if (brick_px_s[0]) begin
      colour_s = COL_RED;
    end else if (brick_px_s[1]) begin
      colour_s = COL_GREEN;
    end else if (brick_px_s[2]) begin
      colour_s = COL_YELLOW;
    end else begin
      case (view_s.state)
        ST_LOST: colour_s = COL_RED;
        ST_WON:  colour_s = COL_GREEN;
        default: colour_s = COL_BLACK;
      endcase
    end
  end

  // Output stage: colour, delayed syncs and game_over share one pixel of latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_r       <= COL_BLACK;
      hsync_r     <= 1'b1;
      vsync_r     <= 1'b1;
      game_over_r <= 1'b0;
    end else if (vga.enable) begin
      rgb_r       <= colour_s;
      hsync_r     <= vga.Hsync_in;
      vsync_r     <= vga.Vsync_in;
      game_over_r <= (view_s.state == ST_LOST) || (view_s.state == ST_WON);
    end
  end

  assign vga.rgb   = rgb_r;
  assign vga.Hsync = hsync_r;
  assign vga.Vsync = vsync_r;
  assign game_over = game_over_r;

endmodule
